// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of one shared memory.
// One access per three cycles: IDLE grants, ACCESS drives memory, RESP acks.
module mem_arbiter #(
  parameter int NUM_OF_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_fault,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_fault,
  output logic [31:0] mem_address,
  output logic        mem_write_en,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        busy
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_ACCESS = 2'd1;
  localparam logic [1:0]  S_RESP   = 2'd2;
  localparam logic        GRANT_I  = 1'b0;
  localparam logic        GRANT_D  = 1'b1;
  localparam logic [31:0] MAX_ADDR = 32'(NUM_OF_BYTES - 4);

  logic [1:0]  r_state;
  logic        r_last_grant;
  logic        r_sel;
  logic [31:0] r_addr;
  logic        r_we;
  logic [31:0] r_wdata;
  logic        r_fault;
  logic [31:0] r_i_rdata;
  logic        r_i_fault;
  logic [31:0] r_d_rdata;
  logic        r_d_fault;

  logic        w_grant_d;
  logic [31:0] w_sel_addr;
  logic        w_fault;
  logic [31:0] w_rdata;

  // D wins when alone, or on a tie when I was granted last.
  assign w_grant_d  = d_req & (~i_req | (r_last_grant == GRANT_I));
  assign w_sel_addr = w_grant_d ? d_addr : i_addr;
  assign w_fault    = (w_sel_addr[1:0] != 2'b00) | (w_sel_addr > MAX_ADDR);
  assign w_rdata    = (r_we | r_fault) ? 32'd0 : mem_read_data;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= GRANT_D;
      r_sel        <= GRANT_I;
      r_addr       <= 32'd0;
      r_we         <= 1'b0;
      r_wdata      <= 32'd0;
      r_fault      <= 1'b0;
      r_i_rdata    <= 32'd0;
      r_i_fault    <= 1'b0;
      r_d_rdata    <= 32'd0;
      r_d_fault    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req | d_req) begin
            r_state      <= S_ACCESS;
            r_sel        <= w_grant_d;
            r_last_grant <= w_grant_d;
            r_addr       <= w_sel_addr;
            r_we         <= w_grant_d & d_we;
            r_wdata      <= w_grant_d ? d_wdata : 32'd0;
            r_fault      <= w_fault;
          end
        end
        S_ACCESS: begin
          r_state <= S_RESP;
          if (r_sel == GRANT_D) begin
            r_d_rdata <= w_rdata;
            r_d_fault <= r_fault;
          end else begin
            r_i_rdata <= w_rdata;
            r_i_fault <= r_fault;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory strobes are decoded from state alone, so reset drops them at once.
  assign mem_address    = (r_state == S_ACCESS) ? r_addr : 32'd0;
  assign mem_write_en   = (r_state == S_ACCESS) & r_we & ~r_fault;
  assign mem_write_data = (r_state == S_ACCESS) ? r_wdata : 32'd0;

  assign i_ack   = (r_state == S_RESP) & (r_sel == GRANT_I);
  assign d_ack   = (r_state == S_RESP) & (r_sel == GRANT_D);
  assign i_rdata = r_i_rdata;
  assign i_fault = r_i_fault;
  assign d_rdata = r_d_rdata;
  assign d_fault = r_d_fault;
  assign busy    = (r_state != S_IDLE);

endmodule
